// File: rtl/carry_lookahead_adder_if.sv
// Operand/result bundle for carry_lookahead_adder.
// OVF/OVF_Q exist only when CLA_OVERFLOW_EN is defined.
interface carry_lookahead_adder_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             in_valid;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             GP;
    logic             GG;
    logic [WIDTH-1:0] SUM_Q;
    logic             COUT_Q;
    logic             out_valid;
`ifdef CLA_OVERFLOW_EN
    logic             OVF;
    logic             OVF_Q;
`endif

    modport master (
        output A, B, CIN, in_valid,
`ifdef CLA_OVERFLOW_EN
        input  OVF, OVF_Q,
`endif
        input  SUM, COUT, GP, GG, SUM_Q, COUT_Q, out_valid
    );

    modport slave (
        input  A, B, CIN, in_valid,
`ifdef CLA_OVERFLOW_EN
        output OVF, OVF_Q,
`endif
        output SUM, COUT, GP, GG, SUM_Q, COUT_Q, out_valid
    );
endinterface

// File: rtl/carry_lookahead_adder.sv
// Multi-level 4-bit-group carry-lookahead adder with a registered result copy.
// Define CLA_OVERFLOW_EN to add the signed-overflow outputs OVF/OVF_Q.
module carry_lookahead_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    carry_lookahead_adder_if.slave bus
);

    function automatic int unsigned node_count(input int unsigned level);
        int unsigned n;
        n = WIDTH;
        for (int unsigned i = 0; i < level; i++) n = (n + 3) / 4;
        return n;
    endfunction

    function automatic int unsigned level_count();
        int unsigned n;
        int unsigned lv;
        n  = WIDTH;
        lv = 0;
        while (n > 1) begin
            n  = (n + 3) / 4;
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int unsigned NLEV = level_count();

    // Fully expanded carry into position n of a 4-wide group: OR of g[t]&p[t+1..n-1] terms plus ci&p[0..n-1].
    function automatic logic lookahead(input logic [3:0] p, input logic [3:0] g,
                                       input logic ci, input int unsigned n);
        logic r;
        logic term;
        r = 1'b0;
        for (int unsigned t = 0; t < 4; t++) begin
            if (t < n) begin
                term = g[t];
                for (int unsigned u = 0; u < 4; u++)
                    if (u > t && u < n) term = term & p[u];
                r = r | term;
            end
        end
        term = ci;
        for (int unsigned u = 0; u < 4; u++)
            if (u < n) term = term & p[u];
        return r | term;
    endfunction

    // Level 0 holds bits; level k node j covers level k-1 nodes 4j..4j+3.
    logic [WIDTH-1:0] lp [0:NLEV];
    logic [WIDTH-1:0] lg [0:NLEV];
    logic [WIDTH-1:0] lc [0:NLEV];
    logic [3:0]       p4;
    logic [3:0]       g4;
    int unsigned      idx;

    always_comb begin
        p4  = '1;
        g4  = '0;
        idx = 0;
        // Absent nodes act as pure pass-through (p=1, g=0) so partial groups stay exact.
        for (int unsigned k = 0; k <= NLEV; k++) begin
            lp[k] = '1;
            lg[k] = '0;
            lc[k] = '0;
        end
        lp[0] = bus.A ^ bus.B;
        lg[0] = bus.A & bus.B;

        for (int unsigned k = 1; k <= NLEV; k++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (j < node_count(k)) begin
                    p4 = '1;
                    g4 = '0;
                    for (int unsigned b = 0; b < 4; b++) begin
                        idx = 4 * j + b;
                        if (idx < WIDTH) begin
                            p4[b] = lp[k-1][idx];
                            g4[b] = lg[k-1][idx];
                        end
                    end
                    lp[k][j] = &p4;
                    lg[k][j] = lookahead(p4, g4, 1'b0, 4);
                end
            end
        end

        lc[NLEV][0] = bus.CIN;
        for (int unsigned k = NLEV; k >= 1; k--) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (j < node_count(k)) begin
                    p4 = '1;
                    g4 = '0;
                    for (int unsigned b = 0; b < 4; b++) begin
                        idx = 4 * j + b;
                        if (idx < WIDTH) begin
                            p4[b] = lp[k-1][idx];
                            g4[b] = lg[k-1][idx];
                        end
                    end
                    for (int unsigned b = 0; b < 4; b++) begin
                        idx = 4 * j + b;
                        if (idx < WIDTH) lc[k-1][idx] = lookahead(p4, g4, lc[k][j], b);
                    end
                end
            end
        end
    end

    assign bus.SUM  = lp[0] ^ lc[0];
    assign bus.GP   = lp[NLEV][0];
    assign bus.GG   = lg[NLEV][0];
    assign bus.COUT = lg[NLEV][0] | (lp[NLEV][0] & bus.CIN);

`ifdef CLA_OVERFLOW_EN
    assign bus.OVF = bus.COUT ^ lc[0][WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.SUM_Q     <= '0;
            bus.COUT_Q    <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef CLA_OVERFLOW_EN
            bus.OVF_Q     <= 1'b0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.SUM_Q  <= bus.SUM;
                bus.COUT_Q <= bus.COUT;
`ifdef CLA_OVERFLOW_EN
                bus.OVF_Q  <= bus.OVF;
`endif
            end
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and exhaustive checks of carry_lookahead_adder at WIDTH=4 and WIDTH=16.
// Overflow checks are compiled in with CLA_OVERFLOW_EN.
module tb_carry_lookahead_adder;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    carry_lookahead_adder_if #(.WIDTH(4))  bus4 ();
    carry_lookahead_adder_if #(.WIDTH(16)) bus16 ();

    carry_lookahead_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    carry_lookahead_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       co;
    } vec_t;

    vec_t vecs [5] = '{
        '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0},
        '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0},
        '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1},
        '{4'hC, 4'h2, 1'b1, 4'hF, 1'b0},
        '{4'h7, 4'hF, 1'b1, 4'h7, 1'b1}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic v);
        bus4.A        = a;
        bus4.B        = b;
        bus4.CIN      = cin;
        bus4.in_valid = v;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        int sa;
        int sb;
        logic [15:0] a16;
        logic [15:0] b16;
        logic        c16;
        logic [16:0] r16;
        logic [3:0]  a4;
        logic [3:0]  b4;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive4(4'hF, 4'h1, 1'b0, 1'b1);
        bus16.A = '0; bus16.B = '0; bus16.CIN = 1'b0; bus16.in_valid = 1'b0;

        // Reset holds registered outputs low even with in_valid asserted across an edge
        #1;
        check("rst_sum_q", 32'(bus4.SUM_Q), 32'h0);
        check("rst_cout_q", 32'(bus4.COUT_Q), 32'h0);
        check("rst_out_valid", 32'(bus4.out_valid), 32'h0);
        edge_sample();
        check("rst_hold_cout_q", 32'(bus4.COUT_Q), 32'h0);
        check("rst_hold_out_valid", 32'(bus4.out_valid), 32'h0);
`ifdef CLA_OVERFLOW_EN
        check("rst_ovf_q", 32'(bus4.OVF_Q), 32'h0);
`endif

        // Combinational directed sums
        bus4.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            #5;
            check($sformatf("dir%0d_sum", i), 32'(bus4.SUM), 32'(vecs[i].s));
            check($sformatf("dir%0d_cout", i), 32'(bus4.COUT), 32'(vecs[i].co));
        end

        // Group propagate/generate
        drive4(4'hA, 4'h5, 1'b0, 1'b0);
        #5;
        check("gp_a_gp", 32'(bus4.GP), 32'h1);
        check("gp_a_gg", 32'(bus4.GG), 32'h0);
        check("gp_a_cout0", 32'(bus4.COUT), 32'h0);
        bus4.CIN = 1'b1;
        #5;
        check("gp_a_cout1", 32'(bus4.COUT), 32'h1);
        check("gp_a_sum1", 32'(bus4.SUM), 32'h0);
        check("gp_a_gg_cin1", 32'(bus4.GG), 32'h0);
        drive4(4'h8, 4'h8, 1'b0, 1'b0);
        #5;
        check("gg_gp", 32'(bus4.GP), 32'h0);
        check("gg_gg", 32'(bus4.GG), 32'h1);

        // Exhaustive WIDTH=4 against integer arithmetic
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = a[3:0];
                    b4 = b[3:0];
                    drive4(a4, b4, ci[0], 1'b0);
                    #5;
                    r = a + b + ci;
                    check($sformatf("exh_%0d_%0d_%0d", a, b, ci),
                          32'({bus4.COUT, bus4.SUM}), 32'(r[4:0]));
                    if (ci == 0) begin
                        check($sformatf("exh_gp_%0d_%0d", a, b), 32'(bus4.GP), 32'((a ^ b) == 15));
                        check($sformatf("exh_gg_%0d_%0d", a, b), 32'(bus4.GG), 32'(r > 15));
                    end
`ifdef CLA_OVERFLOW_EN
                    sa = (a > 7) ? a - 16 : a;
                    sb = (b > 7) ? b - 16 : b;
                    check($sformatf("exh_ovf_%0d_%0d_%0d", a, b, ci), 32'(bus4.OVF),
                          32'(((sa + sb + ci) > 7) || ((sa + sb + ci) < -8)));
`endif
                end
            end
        end

`ifdef CLA_OVERFLOW_EN
        drive4(4'h7, 4'h1, 1'b0, 1'b0);
        #5;
        check("ovf_pos", 32'(bus4.OVF), 32'h1);
        drive4(4'hF, 4'h1, 1'b0, 1'b0);
        #5;
        check("ovf_none", 32'(bus4.OVF), 32'h0);
`endif

        // Registered path: capture, hold, back-to-back
        @(negedge clk);
        rst_n = 1'b1;
        drive4(4'hF, 4'h1, 1'b0, 1'b1);
        edge_sample();
        check("cap_sum_q", 32'(bus4.SUM_Q), 32'h0);
        check("cap_cout_q", 32'(bus4.COUT_Q), 32'h1);
        check("cap_out_valid", 32'(bus4.out_valid), 32'h1);
        drive4(4'h1, 4'h1, 1'b0, 1'b0);
        edge_sample();
        check("hold_sum_q", 32'(bus4.SUM_Q), 32'h0);
        check("hold_cout_q", 32'(bus4.COUT_Q), 32'h1);
        check("hold_out_valid", 32'(bus4.out_valid), 32'h0);
        edge_sample();
        check("hold2_sum_q", 32'(bus4.SUM_Q), 32'h0);
        drive4(4'h3, 4'h4, 1'b0, 1'b1);
        edge_sample();
        check("b2b0_sum_q", 32'(bus4.SUM_Q), 32'h7);
        check("b2b0_cout_q", 32'(bus4.COUT_Q), 32'h0);
        drive4(4'h9, 4'h9, 1'b1, 1'b1);
        edge_sample();
        check("b2b1_sum_q", 32'(bus4.SUM_Q), 32'h3);
        check("b2b1_cout_q", 32'(bus4.COUT_Q), 32'h1);
        check("b2b1_out_valid", 32'(bus4.out_valid), 32'h1);
`ifdef CLA_OVERFLOW_EN
        drive4(4'h7, 4'h1, 1'b0, 1'b1);
        edge_sample();
        check("cap_ovf_q", 32'(bus4.OVF_Q), 32'h1);
`endif
        drive4(4'h5, 4'h6, 1'b0, 1'b1);
        edge_sample();
        check("pre_rst_sum_q", 32'(bus4.SUM_Q), 32'hB);

        // Mid-stream reset clears immediately; first strobe after release is captured
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum_q", 32'(bus4.SUM_Q), 32'h0);
        check("mid_rst_cout_q", 32'(bus4.COUT_Q), 32'h0);
        check("mid_rst_out_valid", 32'(bus4.out_valid), 32'h0);
`ifdef CLA_OVERFLOW_EN
        check("mid_rst_ovf_q", 32'(bus4.OVF_Q), 32'h0);
`endif
        edge_sample();
        rst_n = 1'b1;
        drive4(4'h3, 4'h4, 1'b0, 1'b1);
        edge_sample();
        check("post_rst_sum_q", 32'(bus4.SUM_Q), 32'h7);
        check("post_rst_out_valid", 32'(bus4.out_valid), 32'h1);
        bus4.in_valid = 1'b0;

        // WIDTH=16: boundary and random vectors
        bus16.A = 16'hFFFF; bus16.B = 16'h0000; bus16.CIN = 1'b1;
        #5;
        check("w16_ripple_all", 32'({bus16.COUT, bus16.SUM}), 32'h10000);
        check("w16_gp", 32'(bus16.GP), 32'h1);
        check("w16_gg", 32'(bus16.GG), 32'h0);
        bus16.A = 16'h8000; bus16.B = 16'h8000; bus16.CIN = 1'b0;
        #5;
        check("w16_gg_top", 32'(bus16.GG), 32'h1);
        for (int i = 0; i < 200; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            bus16.A = a16; bus16.B = b16; bus16.CIN = c16;
            #5;
            r16 = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
            check($sformatf("w16_rand%0d_%h_%h_%0d", i, a16, b16, c16),
                  32'({bus16.COUT, bus16.SUM}), 32'(r16));
        end
        bus16.A = 16'hFFFF; bus16.B = 16'h0001; bus16.CIN = 1'b0; bus16.in_valid = 1'b1;
        edge_sample();
        check("w16_sum_q", 32'(bus16.SUM_Q), 32'h0);
        check("w16_cout_q", 32'(bus16.COUT_Q), 32'h1);
        check("w16_out_valid", 32'(bus16.out_valid), 32'h1);
        bus16.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/carry_lookahead_adder.md
# carry_lookahead_adder

Registered-capable carry-lookahead adder computing {COUT, SUM} = A + B + CIN, built from 4-bit lookahead groups with a second-level group-carry lookahead. It exposes a zero-latency combinational result plus a one-cycle registered copy with a valid flag. It is a datapath leaf for ALU and address-generation paths, and its group propagate/generate outputs allow hierarchical chaining of wider adders.

## Interface
- WIDTH, 4, operand width; a multiple of 4, minimum 4.
- clk  in  1  rising-edge clock for the registered outputs.
- rst_n  in  1  asynchronous active-low reset.
- A  in  WIDTH  operand A, unsigned, or two's complement when overflow logic is enabled.
- B  in  WIDTH  operand B.
- CIN  in  1  carry in.
- in_valid  in  1  capture strobe for the registered outputs.
- SUM  out  WIDTH  combinational sum.
- COUT  out  1  combinational carry out, c[WIDTH].
- GP  out  1  block propagate: AND of all p[i].
- GG  out  1  block generate: carry out with CIN=0.
- SUM_Q  out  WIDTH  registered SUM.
- COUT_Q  out  1  registered COUT.
- out_valid  out  1  registered in_valid.
- OVF, OVF_Q  out  1 each  signed overflow, combinational and registered. Present only with CLA_OVERFLOW_EN.

## Operation
- Per bit: p[i] = A[i]^B[i], g[i] = A[i]&B[i], with c[0] = CIN.
- Within each 4-bit group, carries use fully expanded lookahead equations. Example: c1 = g0|p0c0, and c4 = g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0.
- Each group produces group propagate P_k and group generate G_k.
- Group carry-ins come from a second-level lookahead over (P_k, G_k), with no ripple between groups. For WIDTH > 16, the second level itself is grouped in fours.
- SUM[i] = p[i]^c[i] and COUT = c[WIDTH].
- The result must equal the full-width arithmetic sum A + B + CIN, taken mod 2^(WIDTH+1), for all inputs.
- GP = 1 exactly when every p[i] = 1, which means CIN propagates straight to COUT.
- GG is independent of CIN.

## Timing
- SUM, COUT, GP, GG and OVF are purely combinational with zero latency. They do not depend on clk or rst_n.
- Registered path, on rising clk:
  - If in_valid = 1: SUM_Q <= SUM, COUT_Q <= COUT, OVF_Q <= OVF.
  - If in_valid = 0: those registers hold their value.
  - out_valid <= in_valid every cycle, so a capture is visible the cycle after it is strobed.
- Reset: while rst_n = 0, SUM_Q = 0, COUT_Q = 0, OVF_Q = 0 and out_valid = 0, immediately and without waiting for a clock.
- Reset mid-operation discards any pending capture. The first in_valid after deassertion is captured on that edge.
- Back-to-back in_valid is legal: one result per cycle with 1-cycle latency.

## Configuration
- CLA_OVERFLOW_EN defined:
  - OVF = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement overflow of A + B + CIN.
  - OVF_Q is its registered copy, following the same capture and reset rules as SUM_Q.
- CLA_OVERFLOW_EN undefined:
  - The OVF and OVF_Q ports and their logic are absent.
  - All other behaviour is identical.

## Test plan
- Basic sums, WIDTH=4, with combinational outputs checked 5 time units after each change:
  - A=0000, B=0000, CIN=0 -> SUM=0000, COUT=0.
  - A=0001, B=0001, CIN=0 -> SUM=0010, COUT=0.
- Carry through all bits:
  - A=1111, B=0001, CIN=0 -> SUM=0000, COUT=1.
  - A=1100, B=0010, CIN=1 -> SUM=1111, COUT=0.
  - A=0111, B=1111, CIN=1 -> SUM=0111, COUT=1.
- Group signals:
  - A=1010, B=0101 -> GP=1, GG=0. Then CIN=1 -> COUT=1 and SUM=0000.
  - A=1000, B=1000 -> GP=0, GG=1.
- Registered path:
  - Hold rst_n=0 -> SUM_Q=0, COUT_Q=0, out_valid=0 asynchronously.
  - Release rst_n, then drive A=1111, B=0001 with in_valid=1 for one cycle -> next edge gives SUM_Q=0000, COUT_Q=1, out_valid=1.
  - With in_valid=0 thereafter -> SUM_Q and COUT_Q hold, out_valid=0.
  - Assert rst_n=0 mid-stream -> all registered outputs clear immediately.
- Exhaustive and overflow checks:
  - WIDTH=4: all 512 combinations of A, B and CIN match A+B+CIN.
  - WIDTH=16: random vectors match.
  - With CLA_OVERFLOW_EN: A=0111, B=0001, CIN=0 -> OVF=1; A=1111, B=0001 -> OVF=0.
